// File: rtl/bresenham_line_engine.sv
// All-octant Bresenham line rasteriser: endpoints in via start/busy, pixels out via valid/ready.
// Define LINE_CLIP_EN to add clip_xmax/clip_ymax; clipped pixels are stepped over silently.
module bresenham_line_engine #(
    parameter int unsigned COORD_W = 10,
    parameter int unsigned ERR_W   = COORD_W + 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
`ifdef LINE_CLIP_EN
    input  logic [COORD_W-1:0] clip_xmax,
    input  logic [COORD_W-1:0] clip_ymax,
`endif
    output logic               busy,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_last,
    output logic               done
);

    typedef enum logic [1:0] {StIdle, StSetup, StEmit, StDone} state_e;

    state_e                     state_q, state_d;
    logic [COORD_W-1:0]         x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
`ifdef LINE_CLIP_EN
    logic [COORD_W-1:0]         clip_xmax_q, clip_xmax_d, clip_ymax_q, clip_ymax_d;
`endif
    logic signed [ERR_W-1:0]    dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                       sx_q, sx_d, sy_q, sy_d;
    logic                       busy_q, busy_d, done_q, done_d;
    logic                       pix_valid_q, pix_valid_d, pix_last_q, pix_last_d;
    logic [COORD_W-1:0]         pix_x_q, pix_x_d, pix_y_q, pix_y_d;

    logic [COORD_W-1:0]         adx, ady;
    logic signed [ERR_W-1:0]    adx_e, ady_e;
    logic signed [ERR_W:0]      e2, dx_ext, dy_ext;
    logic                       step_x, step_y, at_end, advance, clip_d, end_d;

    assign adx    = (x0_q < x1_q) ? x1_q - x0_q : x0_q - x1_q;
    assign ady    = (y0_q < y1_q) ? y1_q - y0_q : y0_q - y1_q;
    assign adx_e  = ERR_W'(adx);
    assign ady_e  = ERR_W'(ady);

    // e2 carries one extra bit so doubling the error can never overflow.
    assign e2     = {err_q, 1'b0};
    assign dx_ext = {dx_q[ERR_W-1], dx_q};
    assign dy_ext = {dy_q[ERR_W-1], dy_q};
    assign step_x = (e2 >= dy_ext);
    assign step_y = (e2 <= dx_ext);

    assign at_end  = (pix_x_q == x1_q) && (pix_y_q == y1_q);
    // A clipped pixel is held with pix_valid low and stepped past without a handshake.
    assign advance = pix_valid_q ? pix_ready : 1'b1;

    always_comb begin
        state_d     = state_q;
        x0_d        = x0_q;
        y0_d        = y0_q;
        x1_d        = x1_q;
        y1_d        = y1_q;
`ifdef LINE_CLIP_EN
        clip_xmax_d = clip_xmax_q;
        clip_ymax_d = clip_ymax_q;
`endif
        dx_d        = dx_q;
        dy_d        = dy_q;
        err_d       = err_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pix_valid_d = pix_valid_q;
        pix_last_d  = pix_last_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        clip_d      = 1'b0;
        end_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    x0_d    = x0;
                    y0_d    = y0;
                    x1_d    = x1;
                    y1_d    = y1;
`ifdef LINE_CLIP_EN
                    clip_xmax_d = clip_xmax;
                    clip_ymax_d = clip_ymax;
`endif
                    busy_d  = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                dx_d    = adx_e;
                dy_d    = -ady_e;
                err_d   = adx_e - ady_e;
                sx_d    = (x0_q < x1_q);
                sy_d    = (y0_q < y1_q);
                pix_x_d = x0_q;
                pix_y_d = y0_q;
                state_d = StEmit;
            end
            StEmit: begin
                if (advance) begin
                    if (at_end) begin
                        pix_valid_d = 1'b0;
                        pix_last_d  = 1'b0;
                        done_d      = 1'b1;
                        state_d     = StDone;
                    end else begin
                        if (step_x && step_y) begin
                            err_d = err_q + dy_q + dx_q;
                        end else if (step_x) begin
                            err_d = err_q + dy_q;
                        end else if (step_y) begin
                            err_d = err_q + dx_q;
                        end
                        if (step_x) begin
                            pix_x_d = sx_q ? pix_x_q + COORD_W'(1) : pix_x_q - COORD_W'(1);
                        end
                        if (step_y) begin
                            pix_y_d = sy_q ? pix_y_q + COORD_W'(1) : pix_y_q - COORD_W'(1);
                        end
                    end
                end
            end
            StDone: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

`ifdef LINE_CLIP_EN
        clip_d = (pix_x_d > clip_xmax_q) || (pix_y_d > clip_ymax_q);
        if (state_q == StIdle) begin
            clip_d = 1'b0;
        end
`endif
        end_d = (pix_x_d == x1_q) && (pix_y_d == y1_q);

        // Output qualifiers follow the pixel about to be presented.
        if ((state_q == StSetup) || ((state_q == StEmit) && advance && !at_end)) begin
            pix_valid_d = !clip_d;
            pix_last_d  = end_d && !clip_d;
        end

        if (abort && (state_q != StIdle)) begin
            state_d     = StIdle;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            pix_valid_d = 1'b0;
            pix_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            x0_q        <= '0;
            y0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
`ifdef LINE_CLIP_EN
            clip_xmax_q <= '0;
            clip_ymax_q <= '0;
`endif
            dx_q        <= '0;
            dy_q        <= '0;
            err_q       <= '0;
            sx_q        <= 1'b0;
            sy_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
`ifdef LINE_CLIP_EN
            clip_xmax_q <= clip_xmax_d;
            clip_ymax_q <= clip_ymax_d;
`endif
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            err_q       <= err_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pix_valid = pix_valid_q;
    assign pix_last  = pix_last_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;

endmodule

// File: tb/tb_bresenham_line_engine.sv
// Scoreboard bench for bresenham_line_engine: stimulus pushes expected pixels, a monitor pops them.
// The clip test is built only when LINE_CLIP_EN is defined.
module tb_bresenham_line_engine;

    localparam int CW = 10;

    typedef struct packed {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          last;
    } px_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
`ifdef LINE_CLIP_EN
    logic [CW-1:0] clip_xmax = '1, clip_ymax = '1;
`endif
    logic          busy, pix_valid, pix_last, done;
    logic          pix_ready = 1'b1;
    logic [CW-1:0] pix_x, pix_y;

    int  errors = 0;
    int  checks = 0;
    int  done_seen = 0;
    int  done_exp = 0;
    bit  bp_mode = 1'b0;
    px_t sb[$];
    px_t e;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_px = '0;

    bresenham_line_engine #(.COORD_W(CW), .ERR_W(CW + 2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .abort     (abort),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
`ifdef LINE_CLIP_EN
        .clip_xmax (clip_xmax),
        .clip_ymax (clip_ymax),
`endif
        .busy      (busy),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_last  (pix_last),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push(input int x, input int y, input bit last);
        px_t p;
        p.x    = CW'(x);
        p.y    = CW'(y);
        p.last = last;
        sb.push_back(p);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int ax0, input int ay0, input int ax1, input int ay1);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        x0    = CW'(ax0);
        y0    = CW'(ay0);
        x1    = CW'(ax1);
        y1    = CW'(ay1);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_seen != done_exp && n < 200) begin
            tick();
            n++;
        end
        check(name, done_seen, done_exp);
        check({name, "_all_pixels"}, sb.size(), 0);
        repeat (2) tick();
    endtask

    task automatic wait_sb_empty();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            n++;
        end
    endtask

    // Monitor: pixel scoreboard, done counting and stall stability.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("stall_hold", {pix_valid, pix_x, pix_y, pix_last}, prev_px);
            end
            if (done) done_seen++;
            if (pix_valid && pix_ready && !abort) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_pixel: got (%0d,%0d) last=%0b, required none",
                             pix_x, pix_y, pix_last);
                end else begin
                    e = sb.pop_front();
                    check("pixel", {pix_x, pix_y, pix_last}, {e.x, e.y, e.last});
                end
            end
            prev_hold = pix_valid && !pix_ready && !abort;
            prev_px   = {11'b0, pix_valid, pix_x, pix_y, pix_last};
        end
    end

    initial begin
        int ph = 0;
        forever begin
            tick();
            if (bp_mode) begin
                pix_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end else begin
                pix_ready = 1'b1;
                ph = 0;
            end
        end
    end

    initial begin
        int cyc;
        #3;
        check("reset_outputs", {busy, pix_valid, pix_x, pix_y, pix_last, done}, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Shallow line with latency and throughput checks.
        push(0, 0, 0); push(1, 0, 0); push(2, 1, 0);
        push(3, 1, 0); push(4, 2, 0); push(5, 2, 1);
        launch(0, 0, 5, 2);
        check("setup_busy_novalid", {busy, pix_valid}, 2'b10);
        tick();
        check("first_pixel_latency", {pix_valid, pix_x, pix_y}, {1'b1, 20'd0});
        cyc = 0;
        while (!done && cyc < 50) begin
            tick();
            cyc++;
        end
        check("shallow_cycles_to_done", cyc, 6);
        done_exp++;
        tick();
        check("busy_falls", busy, 0);
        wait_done("shallow_done");

        // Steep reverse.
        for (int i = 7; i >= 3; i--) push(3, i, i == 3);
        launch(3, 7, 3, 3);
        done_exp++;
        wait_done("steep_done");

        // Diagonal toward origin.
        for (int i = 5; i >= 0; i--) push(i, i, i == 0);
        launch(5, 5, 0, 0);
        done_exp++;
        wait_done("diag_done");

        // Backpressure.
        bp_mode = 1'b1;
        push(0, 0, 0); push(1, 0, 0); push(2, 1, 0); push(3, 1, 0); push(4, 1, 1);
        launch(0, 0, 4, 1);
        done_exp++;
        wait_done("bp_done");
        bp_mode = 1'b0;
        tick();

        // Degenerate with a start pulsed while busy.
        push(9, 9, 1);
        launch(9, 9, 9, 9);
        x0 = 10'd1; y0 = 10'd1; x1 = 10'd4; y1 = 10'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        done_exp++;
        wait_done("degen_done");
        repeat (8) tick();
        check("degen_no_extra_done", done_seen, done_exp);

        // Abort after the second pixel.
        push(0, 0, 0); push(1, 0, 0);
        launch(0, 0, 8, 0);
        wait_sb_empty();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_idle", {pix_valid, busy, done}, 3'b000);
        repeat (5) tick();
        check("abort_no_done", done_seen, done_exp);

        // Reset mid-line.
        push(0, 0, 0); push(1, 0, 0); push(2, 0, 0);
        launch(0, 0, 8, 0);
        wait_sb_empty();
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {busy, pix_valid, pix_x, pix_y, pix_last, done}, 0);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        check("reset_no_done", done_seen, done_exp);

        // Fresh line after reset.
        push(2, 3, 0); push(1, 2, 0); push(1, 1, 0); push(0, 0, 1);
        launch(2, 3, 0, 0);
        done_exp++;
        wait_done("post_reset_done");

`ifdef LINE_CLIP_EN
        clip_xmax = 10'd3;
        for (int i = 0; i <= 3; i++) push(i, 0, 0);
        launch(0, 0, 6, 0);
        done_exp++;
        wait_done("clip_done");
        clip_xmax = '1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bresenham_line_engine.md
Name: bresenham_line_engine

Overview:
- Parametrised all-octant Bresenham line rasteriser, successor to the first-octant line drawer in the GPU raster path.
- Accepts endpoint pairs through a start/busy handshake and streams one pixel per accepted transfer through a valid/ready port. The pixel stream feeds the framebuffer writer.
- Handles any slope, either direction and degenerate lines. It supports output backpressure, abort and a one-cycle done pulse.

Parameters:
- COORD_W, 10, width of every coordinate (unsigned, range 0..2^COORD_W-1).
- ERR_W, COORD_W+2, width of the signed error accumulator. It must be at least COORD_W+2.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request to draw a line. It is accepted only when busy=0.
- abort  in  1  synchronous abort; the engine drops the current line.
- x0, y0  in  COORD_W each  start point, sampled when start is accepted.
- x1, y1  in  COORD_W each  end point, sampled when start is accepted.
- busy  out  1  high from the cycle after acceptance until return to IDLE.
- pix_valid  out  1  pix_x/pix_y hold a valid pixel.
- pix_ready  in  1  the downstream side accepts the pixel.
- pix_x, pix_y  out  COORD_W each  current pixel coordinate.
- pix_last  out  1  qualifies the final pixel of the line.
- done  out  1  one-cycle pulse when a line completes (not pulsed on abort).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: busy=0, pix_valid=0, pix_x=0, pix_y=0, pix_last=0, done=0, state=IDLE. Internal registers are cleared to 0.
- States: IDLE, SETUP, EMIT, DONE.
- IDLE
  - If start=1, latch x0/y0/x1/y1 and go to SETUP.
  - start is ignored in every other state.
- SETUP (1 cycle), computing from the latched values:
  - dx = |x1-x0| and dy = -|y1-y0|, both signed ERR_W.
  - sx = +1 if x0<x1, else -1; sy = +1 if y0<y1, else -1.
  - err = dx + dy.
  - cur = (x0, y0).
  - Then go to EMIT.
- EMIT
  - pix_valid=1 and pix_x/pix_y = cur.
  - pix_last=1 when cur == (x1, y1).
- On a transfer (pix_valid & pix_ready) in EMIT:
  - If pix_last, go to DONE.
  - Otherwise compute e2 = 2*err from the old err:
    - if e2 >= dy: x += sx and err += dy;
    - if e2 <= dx: y += sy and err += dx;
    - both updates apply in the same cycle when both conditions hold.
- Backpressure: while pix_valid=1 and pix_ready=0, pix_x, pix_y, pix_last and the internal state stay stable.
- DONE: done=1 for one cycle, pix_valid=0, then go to IDLE. busy falls on entry to IDLE.
- Latency and throughput:
  - If start is accepted at edge N, busy=1 and the state is SETUP after edge N.
  - The first pix_valid is asserted after edge N+1.
  - Throughput is one pixel per cycle with pix_ready held high.
- Pixel count is max(|x1-x0|, |y1-y0|) + 1, with no duplicated or skipped pixels. The sequence is monotonic in the major axis.
- Degenerate line (x0==x1 and y0==y1): exactly one pixel is emitted, with pix_last=1.
- Arithmetic: all err math is signed ERR_W. Coordinate increments wrap modulo 2^COORD_W, but the algorithm never steps past the endpoint, so wrap cannot occur for legal input.
- abort
  - In any non-IDLE state, abort returns the engine to IDLE on the next edge. pix_valid drops and done is not pulsed.
  - abort has priority over a simultaneous transfer.
  - abort in IDLE has no effect, and start is not accepted in the same cycle.
- Reset mid-line: all outputs return to their reset values immediately. No done pulse and no further pixels follow.

Optional Feature:
- Macro: LINE_CLIP_EN.
- When defined, add inputs clip_xmax and clip_ymax (COORD_W each), sampled with the endpoints at start.
- A pixel with x>clip_xmax or y>clip_ymax is a clipped pixel:
  - pix_valid stays 0 for it;
  - the engine steps past it internally in one cycle, with no handshake.
- If the endpoint is clipped, no pix_last is seen, but done still pulses once the endpoint is reached.
- When undefined, the ports are absent and every pixel is emitted.

Test Plan:
- Shallow line: (0,0)->(5,2) with pix_ready=1 -> pixels (0,0),(1,0),(2,1),(3,1),(4,2),(5,2) on 6 consecutive cycles. pix_last only on (5,2); done pulses once, on the next cycle.
- Steep reverse line: (3,7)->(3,3) -> pixels (3,7),(3,6),(3,5),(3,4),(3,3). Octant check: (5,5)->(0,0) gives 6 diagonal pixels decreasing to (0,0).
- Backpressure: (0,0)->(4,1) with pix_ready toggling 1,0,0,1,... -> the pixel is held stable while ready=0. The sequence is identical to the unstalled run and done comes after the 5th transfer.
- Degenerate and start-while-busy: (9,9)->(9,9) -> a single pixel (9,9) with pix_last=1, then done. A second start pulsed while busy=1 is ignored and yields no extra pixels.
- Abort and reset:
  - abort after the 2nd pixel of (0,0)->(8,0) -> pix_valid=0 and busy=0 next cycle, with no done.
  - reset_n low mid-line -> all outputs read 0 asynchronously.
  - A new start then draws correctly.
- Clip (LINE_CLIP_EN): (0,0)->(6,0) with clip_xmax=3 -> only (0,0)..(3,0) are emitted, there is no pix_last, and done pulses after the internal step to (6,0).
